// File: rtl/ps2_dev_xcvr.sv
// ps2_dev_xcvr: PS/2 device-side transceiver sending scancodes and receiving host commands with ack
module ps2_dev_xcvr #(
   parameter int HALF_CLKS = 1000,
   parameter int HALF_BITS = 10,
   parameter int IDLE_CLKS = 1250,
   parameter int IDLE_BITS = 11
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_n_i,
   input  logic [7:0] tx_dat_i,
   input  logic       tx_stb_i,
   output logic       tx_rdy_o,
   output logic [7:0] rx_dat_o,
   output logic       rx_stb_o,
   output logic       rx_err_o,
   inout  wire        ps2_clk_,
   inout  wire        ps2_data_
);
   typedef enum logic [3:0] {WAIT_IDLE, IDLE, TX_HI, TX_LO, TX_STOP, DONE, RX_LO, RX_HI, RX_ACK} state_t;
   localparam logic [HALF_BITS-1:0] HALF_END = HALF_BITS'(HALF_CLKS - 1);
   localparam logic [HALF_BITS-1:0] HALF_MID = HALF_BITS'(HALF_CLKS / 2);
   localparam logic [IDLE_BITS-1:0] IDLE_END = IDLE_BITS'(IDLE_CLKS - 1);
   state_t state;
   logic [1:0] clk_sy, dat_sy;
   logic clk_s, data_s, clk_oe, data_oe;
   logic [HALF_BITS-1:0] tmr;
   logic [IDLE_BITS-1:0] idle_cnt;
   logic [3:0] bcnt, nxt_b;
   logic [7:0] hold_d;
   logic [9:0] rx_sh;
   logic [10:0] tx_frame;
   assign ps2_clk_ = clk_oe ? 1'b0 : 1'bz;
   assign ps2_data_ = data_oe ? 1'b0 : 1'bz;
   assign clk_s = clk_sy[1];
   assign data_s = dat_sy[1];
   assign nxt_b = bcnt + 4'd1;
   assign tx_frame = {1'b1, ~^hold_d, hold_d, 1'b0};
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
      if (!wb_rst_n_i) begin
         clk_sy <= 2'b11;
         dat_sy <= 2'b11;
      end else begin
         clk_sy <= {clk_sy[0], ps2_clk_};
         dat_sy <= {dat_sy[0], ps2_data_};
      end
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
      if (!wb_rst_n_i) begin
         state <= WAIT_IDLE;
         tmr <= '0;
         idle_cnt <= '0;
         bcnt <= '0;
         clk_oe <= 1'b0;
         data_oe <= 1'b0;
         hold_d <= '0;
         rx_sh <= '0;
         tx_rdy_o <= 1'b1;
         rx_dat_o <= '0;
         rx_stb_o <= 1'b0;
         rx_err_o <= 1'b0;
      end else begin
         rx_stb_o <= 1'b0;
         rx_err_o <= 1'b0;
         tmr <= (&tmr) ? tmr : tmr + 1'b1;
         if (tx_stb_i && tx_rdy_o) begin
            hold_d <= tx_dat_i;
            tx_rdy_o <= 1'b0;
         end
         case (state)
            WAIT_IDLE: begin
               idle_cnt <= (clk_s && data_s && idle_cnt != IDLE_END) ? idle_cnt + 1'b1 : '0;
               if (clk_s && data_s && idle_cnt == IDLE_END) state <= IDLE;
            end
            IDLE: begin
               tmr <= '0;
               bcnt <= '0;
               if (clk_s && !data_s) begin
                  clk_oe <= 1'b1;
                  state <= RX_LO;
               end else if (!tx_rdy_o) begin
                  data_oe <= ~tx_frame[0];
                  state <= TX_HI;
               end
            end
            TX_HI: if (tmr == HALF_END) begin
               tmr <= '0;
               // host holding clock low: abandon the frame but keep the byte for a full resend
               if (!clk_s) begin
                  data_oe <= 1'b0;
                  state <= WAIT_IDLE;
               end else begin
                  clk_oe <= 1'b1;
                  state <= TX_LO;
               end
            end
            TX_LO: if (tmr == HALF_END) begin
               tmr <= '0;
               clk_oe <= 1'b0;
               if (bcnt == 4'd10) begin
                  data_oe <= 1'b0;
                  state <= TX_STOP;
               end else begin
                  bcnt <= nxt_b;
                  data_oe <= ~tx_frame[nxt_b];
                  state <= TX_HI;
               end
            end
            TX_STOP: if (tmr == HALF_END) state <= DONE;
            DONE: begin
               tx_rdy_o <= 1'b1;
               state <= WAIT_IDLE;
            end
            RX_LO: if (tmr == HALF_END) begin
               tmr <= '0;
               clk_oe <= 1'b0;
               state <= RX_HI;
            end
            RX_HI: begin
               if (tmr == HALF_MID) rx_sh <= {data_s, rx_sh[9:1]};
               if (tmr == HALF_END) begin
                  tmr <= '0;
                  if (!clk_s || (bcnt == 4'd9 && !rx_sh[9])) begin
                     rx_err_o <= 1'b1;
                     state <= WAIT_IDLE;
                  end else if (bcnt != 4'd9) begin
                     bcnt <= nxt_b;
                     clk_oe <= 1'b1;
                     state <= RX_LO;
                  end else begin
                     clk_oe <= 1'b1;
                     data_oe <= 1'b1;
                     state <= RX_ACK;
                  end
               end
            end
            RX_ACK: if (tmr == HALF_END) begin
               clk_oe <= 1'b0;
               data_oe <= 1'b0;
               if (^rx_sh[8:0]) begin
                  rx_dat_o <= rx_sh[7:0];
                  rx_stb_o <= 1'b1;
               end else rx_err_o <= 1'b1;
               state <= WAIT_IDLE;
            end
            default: state <= WAIT_IDLE;
         endcase
      end
endmodule

// File: tb/tb_ps2_dev_xcvr.sv
// tb_ps2_dev_xcvr: directed vectors and host-model sequences for the PS/2 device transceiver
module tb_ps2_dev_xcvr;
   localparam int HALF = 8;
   localparam int IDLE = 10;
   typedef struct {
      bit          is_rx;
      logic [7:0]  d;
      logic        par;
      logic        stop;
      logic [10:0] frame;
      bit          ack;
      int          stb;
      int          err;
      logic [7:0]  dat;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b0, tx_stb = 1'b0;
   logic [7:0] tx_dat = 8'h00;
   logic host_clk_low = 1'b0, host_data_low = 1'b0;
   wire tx_rdy, rx_stb, rx_err;
   wire [7:0] rx_dat;
   wire ps2_clk, ps2_data;
   int checks = 0, errors = 0, cyc = 0, stb_cnt = 0, err_cnt = 0;
   assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
   assign ps2_data = host_data_low ? 1'b0 : 1'bz;
   pullup (ps2_clk);
   pullup (ps2_data);
   ps2_dev_xcvr #(.HALF_CLKS(HALF), .HALF_BITS(4), .IDLE_CLKS(IDLE), .IDLE_BITS(4)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .tx_dat_i(tx_dat), .tx_stb_i(tx_stb), .tx_rdy_o(tx_rdy),
      .rx_dat_o(rx_dat), .rx_stb_o(rx_stb), .rx_err_o(rx_err), .ps2_clk_(ps2_clk), .ps2_data_(ps2_data));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (rx_stb === 1'b1) stb_cnt <= stb_cnt + 1;
      if (rx_err === 1'b1) err_cnt <= err_cnt + 1;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask
   task automatic wait_fall(input logic prev0, input int lim, output bit ok);
      logic prev;
      prev = prev0;
      ok = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (prev === 1'b1 && ps2_clk === 1'b0) begin
            ok = 1;
            break;
         end
         prev = ps2_clk;
      end
   endtask
   task automatic send_byte(input logic [7:0] d);
      @(negedge clk);
      tx_dat = d;
      tx_stb = 1'b1;
      @(negedge clk);
      tx_stb = 1'b0;
      tx_dat = 8'h00;
      chk("tx_rdy_fall", tx_rdy, 0);
   endtask
   task automatic host_recv(output logic [10:0] fr, output bit sp_ok);
      bit e;
      int last;
      fr = 'x;
      sp_ok = 1;
      last = 0;
      for (int n = 0; n < 11; n++) begin
         wait_fall(ps2_clk, n == 0 ? 400 : 2 * HALF + 4, e);
         if (!e) begin
            checks++;
            errors++;
            $display("FAIL tx_edge %0d got none want falling edge", n);
            return;
         end
         if (n > 0 && cyc - last != 2 * HALF) sp_ok = 0;
         last = cyc;
         fr[n] = ps2_data;
      end
   endtask
   task automatic wait_rdy(output int n);
      n = 0;
      while (tx_rdy !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask
   task automatic host_send(input logic [7:0] d, input logic par, input logic stop, input bit with_stb, output bit ack);
      logic [9:0] b;
      bit e;
      b = {stop, par, d};
      ack = 0;
      @(negedge clk);
      host_data_low = 1'b1;
      if (with_stb) begin
         repeat (2) @(negedge clk);
         tx_dat = 8'h1C;
         tx_stb = 1'b1;
         @(negedge clk);
         tx_stb = 1'b0;
         tx_dat = 8'h00;
      end
      for (int i = 0; i < 10; i++) begin
         wait_fall(i == 0 ? 1'b1 : ps2_clk, 2 * HALF + 4, e);
         if (!e) begin
            checks++;
            errors++;
            $display("FAIL rx_edge %0d got none want falling edge", i);
            host_data_low = 1'b0;
            return;
         end
         host_data_low = ~b[i];
      end
      wait_fall(ps2_clk, 2 * HALF + 4, e);
      ack = e && ps2_data === 1'b0;
      host_data_low = 1'b0;
      repeat (HALF + 4) @(negedge clk);
   endtask
   initial begin
      vec_t v[8];
      logic [10:0] fr;
      bit sp, ack, e;
      int n, s0, e0, falls;
      logic prev;
      v[0] = '{0, 8'hAA, 1'b0, 1'b0, 11'b11101010100, 0, 0, 0, 8'h00};
      v[1] = '{0, 8'h00, 1'b0, 1'b0, 11'b11000000000, 0, 0, 0, 8'h00};
      v[2] = '{0, 8'h01, 1'b0, 1'b0, 11'b10000000010, 0, 0, 0, 8'h00};
      v[3] = '{0, 8'hFF, 1'b0, 1'b0, 11'b11111111110, 0, 0, 0, 8'h00};
      v[4] = '{1, 8'hED, 1'b1, 1'b1, 11'b0, 1, 1, 0, 8'hED};
      v[5] = '{1, 8'hFF, 1'b0, 1'b1, 11'b0, 1, 0, 1, 8'hED};
      v[6] = '{1, 8'h5A, 1'b1, 1'b1, 11'b0, 1, 1, 0, 8'h5A};
      v[7] = '{1, 8'h3C, 1'b1, 1'b0, 11'b0, 0, 0, 1, 8'h5A};
      repeat (3) @(negedge clk);
      chk("rst_tx_rdy", tx_rdy, 1);
      chk("rst_rx_stb", rx_stb, 0);
      chk("rst_rx_err", rx_err, 0);
      chk("rst_rx_dat", rx_dat, 8'h00);
      chk("rst_ps2_clk", ps2_clk, 1);
      chk("rst_ps2_data", ps2_data, 1);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (!v[k].is_rx) begin
            send_byte(v[k].d);
            host_recv(fr, sp);
            chk($sformatf("tx_frame_%02h", v[k].d), fr, v[k].frame);
            chk("tx_spacing", sp, 1);
            wait_rdy(n);
            chk("tx_rdy_rise", n, 2 * HALF + 1);
         end else begin
            repeat (IDLE + HALF + 5) @(negedge clk);
            s0 = stb_cnt;
            e0 = err_cnt;
            host_send(v[k].d, v[k].par, v[k].stop, 0, ack);
            chk($sformatf("rx_ack_%02h", v[k].d), ack, v[k].ack);
            chk($sformatf("rx_stb_%02h", v[k].d), stb_cnt - s0, v[k].stb);
            chk($sformatf("rx_err_%02h", v[k].d), err_cnt - e0, v[k].err);
            chk($sformatf("rx_dat_%02h", v[k].d), rx_dat, v[k].dat);
         end
      end
      repeat (IDLE + HALF + 5) @(negedge clk);
      send_byte(8'hAA);
      for (int k = 0; k < 5; k++) begin
         wait_fall(ps2_clk, k == 0 ? 400 : 2 * HALF + 4, e);
         chk("inh_edge", e, 1);
      end
      n = 0;
      while (ps2_clk !== 1'b1 && n < 2 * HALF) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      host_clk_low = 1'b1;
      repeat (HALF + 2) @(negedge clk);
      chk("inh_data_released", ps2_data, 1);
      chk("inh_byte_held", tx_rdy, 0);
      repeat (4) @(negedge clk);
      host_clk_low = 1'b0;
      host_recv(fr, sp);
      chk("inh_resend_frame", fr, 11'b11101010100);
      chk("inh_resend_spacing", sp, 1);
      wait_rdy(n);
      chk("inh_rdy_rise", n, 2 * HALF + 1);
      repeat (IDLE + HALF + 5) @(negedge clk);
      s0 = stb_cnt;
      e0 = err_cnt;
      host_send(8'h12, 1'b1, 1'b1, 1, ack);
      chk("rts_tx_ack", ack, 1);
      chk("rts_tx_stb", stb_cnt - s0, 1);
      chk("rts_tx_err", err_cnt - e0, 0);
      chk("rts_tx_rx_dat", rx_dat, 8'h12);
      chk("rts_tx_held", tx_rdy, 0);
      host_recv(fr, sp);
      chk("rts_tx_frame_1c", fr, 11'b10000111000);
      wait_rdy(n);
      chk("rts_tx_rdy_rise", n, 2 * HALF + 1);
      send_byte(8'h00);
      for (int k = 0; k < 3; k++) begin
         wait_fall(ps2_clk, k == 0 ? 400 : 2 * HALF + 4, e);
         chk("rst_mid_edge", e, 1);
      end
      repeat (2) @(negedge clk);
      chk("rst_mid_clk_low", ps2_clk, 0);
      s0 = stb_cnt;
      e0 = err_cnt;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_clk_z", ps2_clk, 1);
      chk("rst_mid_data_z", ps2_data, 1);
      chk("rst_mid_rdy", tx_rdy, 1);
      @(negedge clk);
      rst_n = 1'b1;
      falls = 0;
      prev = ps2_clk;
      repeat (3 * IDLE + 6 * HALF) begin
         @(negedge clk);
         if (prev === 1'b1 && ps2_clk === 1'b0) falls++;
         prev = ps2_clk;
      end
      chk("rst_mid_no_resume", falls, 0);
      chk("rst_mid_rdy_after", tx_rdy, 1);
      chk("rst_mid_no_stb", stb_cnt - s0, 0);
      chk("rst_mid_no_err", err_cnt - e0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end
endmodule
